// File: rtl/fft_sched_pkg.sv
// Shared types and constants for the FFT frame scheduler and its tag FIFO.
package fft_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CFG  = 2'd1,
        DATA = 2'd2
    } state_t;

    // Position of the forward/inverse flag inside the core's config word.
    localparam int CFG_FWD_BIT = 0;

    localparam int FRAME_LEN_DEFAULT = 512;

endpackage

// File: rtl/fft_tag_fifo.sv
// Synchronous FIFO of channel tags for frames currently inside the FFT core.
module fft_tag_fifo
    import fft_sched_pkg::*;
#(
    parameter int W     = 2,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full_q, empty_q;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A pop on an empty FIFO is dropped; a push into a full FIFO only lands if a pop frees the slot.
    assign do_pop  = pop_i && !empty_q;
    assign do_push = push_i && (!full_q || do_pop);

    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (do_push) wr_q <= ptr_inc(wr_q);
            if (do_pop)  rd_q <= ptr_inc(rd_q);
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == CW'(DEPTH));
            empty_q <= (cnt_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign head_o  = empty_q ? '0 : mem_q[rd_q];

endmodule

// File: rtl/fft_frame_scheduler.sv
// Round-robin arbiter that feeds whole frames from N_CH sources into one FFT core
// and tags each frame leaving the core with its source channel.
module fft_frame_scheduler
    import fft_sched_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int FRAME_LEN = FRAME_LEN_DEFAULT,
    parameter int DATA_W    = 32,
    parameter int TAG_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          ch_req,
    input  logic [N_CH-1:0]          ch_fwd,
    input  logic [N_CH*DATA_W-1:0]   ch_tdata,
    output logic [N_CH-1:0]          ch_rd,
    output logic [N_CH-1:0]          grant,
    output logic [7:0]               cfg_tdata,
    output logic                     cfg_tvalid,
    input  logic                     cfg_tready,
    output logic [DATA_W-1:0]        fft_tdata,
    output logic                     fft_tvalid,
    input  logic                     fft_tready,
    output logic                     fft_tlast,
    input  logic                     res_tvalid,
    input  logic                     res_tlast,
    output logic [$clog2(N_CH)-1:0]  res_ch,
    output logic                     res_ch_valid,
    output logic                     err,
    input  logic                     evt_tlast_err,
    output state_t                   dbg_state
);

    localparam int CW    = $clog2(N_CH);
    localparam int CNT_W = $clog2(FRAME_LEN);

    // Handshakes: a beat moves on a cycle where valid & ready are both high; valid is never
    // withdrawn and its payload never changes until that cycle.

    state_t            state_q;
    logic [N_CH-1:0]   grant_q;
    logic [CW-1:0]     last_q;
    logic              fwd_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              cfg_tvalid_q;
    logic              fft_tvalid_q;
    logic              err_q;

    logic [CW-1:0]     pick;
    logic [N_CH-1:0]   pick_oh;
    logic              pick_found;
    logic              xfer, last_beat, res_pop;
    logic              tag_full, tag_empty;

    // First requester strictly after the previous winner, wrapping; last_q doubles as the
    // round-robin pointer and the current winner.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        for (int k = 1; k <= N_CH; k++) begin
            if (!pick_found && ch_req[(int'(last_q) + k) % N_CH]) begin
                pick       = CW'((int'(last_q) + k) % N_CH);
                pick_found = 1'b1;
            end
        end
        pick_oh       = '0;
        pick_oh[pick] = 1'b1;
    end

    assign xfer      = (state_q == DATA) && fft_tready;
    assign last_beat = (cnt_q == CNT_W'(FRAME_LEN - 1));
    assign res_pop   = res_tvalid && res_tlast;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_q       <= CW'(N_CH - 1);
            fwd_q        <= 1'b0;
            cnt_q        <= '0;
            cfg_tvalid_q <= 1'b0;
            fft_tvalid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            if ((res_pop && tag_empty) || evt_tlast_err) err_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    // A slot freed by a pop this cycle may be claimed straight away.
                    if (pick_found && (!tag_full || res_pop)) begin
                        state_q      <= CFG;
                        grant_q      <= pick_oh;
                        last_q       <= pick;
                        fwd_q        <= ch_fwd[pick];
                        cfg_tvalid_q <= 1'b1;
                    end
                end
                CFG: begin
                    if (cfg_tready) begin
                        state_q      <= DATA;
                        cfg_tvalid_q <= 1'b0;
                        fft_tvalid_q <= 1'b1;
                    end
                end
                DATA: begin
                    if (fft_tready) begin
                        if (last_beat) begin
                            state_q      <= IDLE;
                            cnt_q        <= '0;
                            grant_q      <= '0;
                            fft_tvalid_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    fft_tag_fifo #(
        .W     (CW),
        .DEPTH (TAG_DEPTH)
    ) u_tags (
        .clk     (clk),
        .rst     (rst),
        .push_i  (xfer && last_beat),
        .pop_i   (res_pop),
        .din_i   (last_q),
        .full_o  (tag_full),
        .empty_o (tag_empty),
        .head_o  (res_ch)
    );

    always_comb begin
        cfg_tdata              = '0;
        cfg_tdata[CFG_FWD_BIT] = fwd_q;
    end

    assign grant        = grant_q;
    assign cfg_tvalid   = cfg_tvalid_q;
    assign fft_tvalid   = fft_tvalid_q;
    assign fft_tdata    = ch_tdata[int'(last_q) * DATA_W +: DATA_W];
    assign fft_tlast    = (state_q == DATA) && last_beat;
    assign ch_rd        = xfer ? grant_q : '0;
    assign res_ch_valid = !tag_empty;
    assign err          = err_q;
    assign dbg_state    = state_q;

endmodule

// File: doc/fft_frame_scheduler.md
# fft_frame_scheduler

Sequences and shares the single FFT core between several sample sources. Each source raises a request when it holds a complete frame. The scheduler picks a source round-robin, issues one config word to the core, and streams exactly FRAME_LEN samples with tlast on the final one. It then tags each output frame of the core with the channel that produced it. The block sits between the per-channel frame buffers and the FFT core's config/data slave ports, and monitors the core's output master port.

## Interface
- N_CH, 4: number of requesting channels (2..8)
- FRAME_LEN, 512: samples per frame (power of two, 8..4096)
- DATA_W, 32: sample width, {im[15:0], re[15:0]} as the core expects
- TAG_DEPTH, 4: maximum frames in flight inside the core
- clk  in  1  system clock
- rst  in  1  reset; one clock domain, synchronous, active-high
- ch_req  in  N_CH  channel i has a full frame ready
- ch_fwd  in  N_CH  direction for channel i: 1 = forward, 0 = inverse
- ch_tdata  in  N_CH*DATA_W  head sample of each channel, slice i
- ch_rd  out  N_CH  one-hot pop strobe to the granted channel
- grant  out  N_CH  one-hot current owner; 0 when idle
- cfg_tdata  out  8  {7'b0, fwd} of the granted channel
- cfg_tvalid  out  1  config word valid
- cfg_tready  in  1  core config ready
- fft_tdata  out  DATA_W  sample to core
- fft_tvalid  out  1  sample valid
- fft_tready  in  1  core data ready
- fft_tlast  out  1  last sample of frame
- res_tvalid  in  1  core output valid (core m_axis_data_tready tied 1)
- res_tlast  in  1  core output last
- res_ch  out  $clog2(N_CH)  channel tag of the frame currently leaving the core
- res_ch_valid  out  1  tag FIFO non-empty
- err  out  1  sticky: tag underflow, or a core tlast_unexpected/tlast_missing event
- evt_tlast_err  in  1  OR of the core's tlast_unexpected and tlast_missing events

## Operation
- FSM states: IDLE, CFG, DATA.
- IDLE → CFG when any ch_req is set and the tag FIFO is not full.
  - The winner is the first requester searching upward (with wrap) from last_grant+1.
  - grant and the round-robin pointer are registered on this transition.
- CFG: cfg_tvalid=1 and cfg_tdata reflects ch_fwd[winner], latched at grant time. On cfg_tvalid & cfg_tready → DATA.
- DATA: fft_tvalid=1 and fft_tdata is the granted slice of ch_tdata.
  - A transfer is fft_tvalid & fft_tready. ch_rd = grant on each transfer.
  - The sample counter (width $clog2(FRAME_LEN)) increments per transfer.
  - fft_tlast=1 while cnt == FRAME_LEN-1.
  - On the last transfer: push the winner id to the tag FIFO, clear cnt and grant, → IDLE.
- ch_req is sampled only in IDLE. Deassertion mid-frame is ignored; the frame completes.
- Tag FIFO:
  - Push on last transfer; pop on res_tvalid & res_tlast.
  - Simultaneous push and pop: both occur, occupancy unchanged.
  - Pop when empty: ignored, err set.
  - Full (TAG_DEPTH entries): IDLE holds and no grant is issued.
- evt_tlast_err sets err. err clears only on rst.
- rst: state=IDLE, grant=0, ch_rd=0, cfg_tvalid=0, fft_tvalid=0, fft_tlast=0, cnt=0, FIFO empty, res_ch_valid=0, res_ch=0, err=0, pointer such that channel 0 wins first. Reset mid-frame abandons the frame without pushing a tag.

## Timing
- req seen in IDLE at cycle t → grant and cfg_tvalid at t+1.
- cfg accepted at t+1 (cfg_tready=1) → fft_tvalid at t+2.
- With fft_tready held high, the frame occupies cycles t+2..t+FRAME_LEN+1, with tlast at t+FRAME_LEN+1.
- Back-to-back frames: FRAME_LEN+2 cycles per frame minimum.
- All outputs registered except the following, which are combinational from state/grant/cnt: fft_tdata, ch_rd, fft_tlast, res_ch.
- fft_tvalid never drops inside a frame. fft_tdata and fft_tlast hold while fft_tready=0.
- cfg_tvalid holds until accepted; cfg_tdata is stable while cfg_tvalid=1.

## Structure
- Shared package fft_sched_pkg contains:
  - state enum {IDLE, CFG, DATA}
  - the CFG_FWD_BIT=0 constant
  - the default FRAME_LEN=512
- Sub-module fft_tag_fifo: synchronous FIFO, width $clog2(N_CH), depth TAG_DEPTH, with push, pop, full, empty and head outputs.
- Round-robin pick and FSM live in the top.

## Test plan
- Single request ch_req=4'b0100, ch_fwd[2]=1, all readies 1:
  - cfg_tdata=8'h01 for 1 cycle.
  - 512 transfers, ch_rd[2] pulsed 512 times, fft_tlast only on transfer 512.
  - Then grant=0.
- All four channels request continuously: grants in order 0,1,2,3,0, each frame 514 cycles apart.
- fft_tready toggles 1-of-3 mid-frame: exactly 512 transfers, data and tlast held during stalls, fft_tvalid never drops.
- Core output held off so 4 frames are in flight:
  - The fifth request is not granted.
  - A single res_tvalid&res_tlast pulse frees one slot; the grant follows 1 cycle later; res_ch reports ids in grant order.
- Push and pop in the same cycle: occupancy unchanged. res_tlast with the FIFO empty: err=1 and stays 1 until rst.
- Assert rst at transfer 200:
  - The next cycle shows all outputs at reset values and the FIFO empty.
  - A new request restarts from channel 0 with cnt=0.
